// File: rtl/direct_sound_fifo_pkg.sv
// Shared sound constants: direct-sound FIFO sizing, DMA request threshold and MMIO word addresses.
// Also holds the byte-lane selector used to pick the next sample out of a 32-bit FIFO word.
package direct_sound_fifo_pkg;

  localparam int SOUND_FIFO_DEPTH      = 8;
  localparam int SOUND_FIFO_REQ_THRESH = 4;
  localparam int SOUND_FIFO_LEVEL_W    = 4;

  localparam logic [31:0] SOUND_FIFO_A_ADDR = 32'h0400_00A0;
  localparam logic [31:0] SOUND_FIFO_B_ADDR = 32'h0400_00A4;

  typedef enum logic {
    SOUND_FIFO_A = 1'b0,
    SOUND_FIFO_B = 1'b1
  } sound_fifo_id_e;

  typedef logic [1:0] byte_idx_t;

  // Byte 0 sits in the low lane and is played first.
  function automatic logic [7:0] sound_byte_sel(input logic [31:0] word, input byte_idx_t idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Word-address match for the MMIO decoder feeding wr_en of each FIFO copy.
  function automatic logic sound_fifo_hit(input logic [31:0] addr, input sound_fifo_id_e id);
    logic [31:0] base;
    base = (id == SOUND_FIFO_A) ? SOUND_FIFO_A_ADDR : SOUND_FIFO_B_ADDR;
    return (addr[31:2] == base[31:2]);
  endfunction

endpackage

// File: rtl/direct_sound_fifo_mem.sv
// Word storage for one direct-sound FIFO: DEPTH x 32 registers, synchronous write, combinational read.
// Contents are deliberately never reset; only the pointers in the controller carry state.
module sound_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/direct_sound_fifo.sv
// Direct-sound sample FIFO: 32-bit words in, one signed byte out per timer tick, level-based DMA request.
// Writes are judged against the level at the start of the cycle, so a full FIFO drops a write even when a tick frees a word.
module direct_sound_fifo
  import direct_sound_fifo_pkg::*;
#(
  parameter int DEPTH      = SOUND_FIFO_DEPTH,
  parameter int REQ_THRESH = SOUND_FIFO_REQ_THRESH
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        enable,
  input  logic        fifo_clear,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        tick,
  output logic [7:0]  sample,
  output logic        sound_req,
  output logic [3:0]  level,
  output logic        overflow,
  output logic        underflow
);

  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [3:0]      DEPTH_LVL  = 4'(DEPTH);
  localparam logic [3:0]      THRESH_LVL = 4'(REQ_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  byte_idx_t     byte_idx_q, byte_idx_d;
  logic [3:0]    level_q, level_d;
  logic [7:0]    sample_q, sample_d;
  logic          sound_req_q, sound_req_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic          word_done;
  logic [31:0]   head_word;

  sound_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (head_word)
  );

  // fifo_clear masks both sides so a discarded write never lands in storage.
  assign full      = (level_q == DEPTH_LVL);
  assign empty     = (level_q == 4'd0);
  assign wr_acc    = wr_en && !full && !fifo_clear;
  assign rd_acc    = tick && !empty && !fifo_clear;
  assign word_done = rd_acc && (byte_idx_q == 2'd3);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    byte_idx_d  = byte_idx_q;
    level_d     = level_q;
    sample_d    = sample_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    // Request reflects the level held at the start of this cycle.
    sound_req_d = enable && (level_q <= THRESH_LVL);

    if (fifo_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_idx_d = '0;
      level_d    = '0;
      sample_d   = '0;
    end else begin
      overflow_d  = wr_en && full;
      underflow_d = tick && empty;

      if (wr_acc) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      end

      if (rd_acc) begin
        sample_d   = sound_byte_sel(head_word, byte_idx_q);
        byte_idx_d = byte_idx_q + 2'd1;
      end

      if (word_done) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      end

      if (wr_acc && !word_done) begin
        level_d = level_q + 4'd1;
      end else if (!wr_acc && word_done) begin
        level_d = level_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      byte_idx_q  <= '0;
      level_q     <= '0;
      sample_q    <= '0;
      sound_req_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      byte_idx_q  <= byte_idx_d;
      level_q     <= level_d;
      sample_q    <= sample_d;
      sound_req_q <= sound_req_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign sample    = sample_q;
  assign sound_req = sound_req_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/direct_sound_fifo.md
DIRECT_SOUND_FIFO -- requirements
Module: direct_sound_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO capacity in 32-bit words.
REQ-002 SHALL have parameter REQ_THRESH, default 4, meaning the word level at or below which a DMA refill is requested.
REQ-003 SHALL have ports, one per line:
  clk         in   1   clock
  rst_b       in   1   reset, asynchronous, active-low
  enable      in   1   channel enabled (SOUNDCNT_H channel-enable bit); gates sound_req only
  fifo_clear  in   1   one-cycle strobe from SOUNDCNT_H FIFO-reset bit
  wr_en       in   1   one-cycle strobe: 32-bit write decoded to this FIFO's address (DMA or CPU)
  wr_data     in   32  write word; byte 0 = [7:0] is played first
  tick        in   1   one-cycle strobe from the selected timer overflow: consume one sample
  sample      out  8   current signed 8-bit sample, registered
  sound_req   out  1   level DMA request to the sound-capable DMA start logic
  level       out  4   words held, including a partially consumed head word (0..DEPTH)
  overflow    out  1   one-cycle pulse: write dropped because FIFO full
  underflow   out  1   one-cycle pulse: tick while FIFO empty

Function
REQ-004 SHALL store words in a circular buffer of DEPTH entries with write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH) and a byte index 0..3 into the head word.
REQ-005 SHALL accept wr_en iff level < DEPTH at the start of the cycle; on acceptance: store at write pointer, advance write pointer, level +1.
REQ-006 SHALL drop wr_en when level == DEPTH, even if the same cycle's tick frees a word; overflow pulses high the next cycle.
REQ-007 On tick with level > 0: sample <= byte[byte index] of head word, registered, visible the cycle after tick; byte index +1.
REQ-008 When a tick consumes byte 3: byte index -> 0, read pointer advances, level -1.
REQ-009 On tick with level == 0: sample holds its value, byte index unchanged, underflow pulses next cycle; a write in that cycle is still accepted.
REQ-010 On accepted write and word-completing tick in the same cycle: level unchanged, both pointers advance.
REQ-011 SHALL drive sound_req = registered (enable && level <= REQ_THRESH), updated one cycle after level changes.
REQ-012 SHALL give fifo_clear priority over wr_en and tick in the same cycle: pointers, byte index, level -> 0, sample -> 0, no overflow/underflow pulse, write discarded.
REQ-013 SHALL NOT clear storage contents on fifo_clear or reset; only pointers and state.
REQ-014 SHALL keep level within 0..DEPTH under all input combinations.

Reset
REQ-015 On rst_b low, asynchronously: pointers 0, byte index 0, level 0, sample 8'h00, sound_req 0, overflow 0, underflow 0.
REQ-016 First rising clk after rst_b deassertion SHALL process inputs normally; sound_req rises that edge if enable is high (level 0 <= REQ_THRESH).

Structure
REQ-017 SHALL place SOUND_FIFO_DEPTH, SOUND_FIFO_REQ_THRESH and the FIFO_A/FIFO_B MMIO word addresses (0x040000A0, 0x040000A4) in the shared sound package; the top instantiates two copies (A, B).
REQ-018 SHALL isolate storage in one sub-module, sound_fifo_mem: DEPTH x 32 register array, one synchronous write port, one combinational read port, no reset.

Verification
REQ-019 Reset, enable=1 -> level 0, sample 0, sound_req 1 one cycle after reset release.
REQ-020 Write 0x04030201, then four ticks -> sample 0x01,0x02,0x03,0x04 on successive post-tick cycles; level 1->0 after fourth tick; fifth tick -> underflow pulse, sample stays 0x04.
REQ-021 Five writes from empty -> sound_req falls after level reaches 5; eight writes then a ninth -> level 8, overflow pulse, ninth word never played.
REQ-022 Level 8, write and fourth-byte tick in same cycle -> write dropped, overflow, level 7.
REQ-023 Level 3, word-completing tick plus write same cycle -> level stays 3; 12 write/drain cycles wrap pointers, data order preserved.
REQ-024 Level 6 mid-word, fifo_clear with simultaneous wr_en and tick -> level 0, sample 0, no pulses, sound_req 1.
